gcd_sched: RTL and testbench
============================

GCD_SCHED -- requirements
Module: gcd_sched

Interface
REQ-001 Parameters SHALL be:
- N_REQ, default 4: number of requesters, minimum 2.
- WIDTH, default 32: operand and result width.
- TIMEOUT_CYC, default 0: watchdog limit in cycles; 0 disables the watchdog.

REQ-002 Ports SHALL be as follows. There is one clock. Reset is asynchronous and active-low.
- csi_clk, in, 1: single clock; all logic is on its rising edge.
- rsi_reset_n, in, 1: asynchronous active-low reset.
- req_valid, in, N_REQ: per-requester request.
- req_ready, out, N_REQ: per-requester accept.
- req_a, in, N_REQ*WIDTH: operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b, in, N_REQ*WIDTH: operand B, same packing as req_a.
- rsp_valid, out, N_REQ: per-requester response valid.
- rsp_ready, in, N_REQ: per-requester response accept.
- rsp_result, out, WIDTH: shared result bus.
- rsp_err, out, 1: response was produced by a watchdog timeout.
- eng_start, out, 1: start pulse to the GCD engine.
- eng_dataa, out, WIDTH: engine operand A.
- eng_datab, out, WIDTH: engine operand B.
- eng_done, in, 1: engine completion, a single-cycle pulse.
- eng_result, in, WIDTH: engine result, valid with eng_done.
- busy, out, 1: high in any state other than IDLE.
- grant_id, out, clog2(N_REQ): index of the current or last grantee.

Function
REQ-003 The block SHALL share one multi-cycle subtractive GCD engine among N_REQ requesters using a four-state FSM: IDLE, ISSUE, WAIT, RESP.

REQ-004 Arbitration in IDLE SHALL be round-robin. The search starts at last_grant+1 modulo N_REQ, and the first requester with req_valid set wins.

REQ-005 In IDLE with a winner g:
- req_ready[g] SHALL be 1 combinationally, and all other req_ready bits 0.
- req_ready SHALL be all-zero in every other state.
- Requesters SHALL NOT make req_valid depend on req_ready.

REQ-006 On acceptance (IDLE and req_valid[g]):
- The block SHALL latch a=req_a[g], b=req_b[g] and grant_id=g on the same edge.
- Later changes on req_a or req_b SHALL have no effect until the next acceptance.

REQ-007 Zero bypass: if the latched a==0 or b==0, the FSM SHALL go IDLE->RESP with result=a|b and rsp_err=0, and eng_start SHALL NOT assert. This covers engine operands that never terminate (a==0, b!=0). A 0,0 request returns 0.

REQ-008 Otherwise the FSM SHALL go IDLE->ISSUE. ISSUE SHALL drive eng_start=1 for exactly one cycle, then go to WAIT.

REQ-009 eng_dataa and eng_datab SHALL equal the latched a and b from ISSUE through the end of WAIT.

REQ-010 In WAIT, on eng_done=1 the block SHALL capture eng_result into rsp_result, set rsp_err=0, and go to RESP.

REQ-011 eng_done seen in IDLE, ISSUE or RESP SHALL be ignored.

REQ-012 Watchdog:
- With TIMEOUT_CYC!=0, a 32-bit counter SHALL clear at ISSUE and increment every WAIT cycle.
- When the count reaches TIMEOUT_CYC without eng_done, the block SHALL go to RESP with rsp_result=0 and rsp_err=1.
- If eng_done and the timeout occur in the same cycle, eng_done SHALL win.

REQ-013 In RESP:
- rsp_valid[grant_id] SHALL be 1 and all other rsp_valid bits 0.
- rsp_result and rsp_err SHALL be held stable until rsp_valid[grant_id] and rsp_ready[grant_id] are both high.
- On that handshake edge, last_grant SHALL become grant_id and the FSM SHALL go to IDLE.

REQ-014 Latency:
- Bypass: rsp_valid SHALL rise 1 cycle after acceptance.
- Engine path: eng_start SHALL assert 1 cycle after acceptance, and rsp_valid SHALL rise 1 cycle after the eng_done pulse.
- After the RESP handshake, a new acceptance is possible on the next cycle (back-to-back, 1 idle cycle).

REQ-015 Only one request SHALL be outstanding at a time; no queueing.

REQ-016 rsp_ready on a non-granted index SHALL be ignored.

Reset
REQ-017 Asserting rsi_reset_n=0 SHALL immediately force the following, without waiting for a clock edge:
- state=IDLE and last_grant=N_REQ-1, so requester 0 wins first;
- req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0;
- eng_start=0, eng_dataa=0, eng_datab=0;
- busy=0, grant_id=0, watchdog count=0.

REQ-018 Reset asserted mid-operation SHALL abandon the request with no response. An eng_done arriving after reset release SHALL be ignored per REQ-011.

REQ-019 Deassertion of reset SHALL be synchronized outside this block. The first arbitration SHALL occur on the first rising edge after release.

Verification
REQ-020 Single request: req 0, a=48, b=18, engine model attached.
- Accept at T and eng_start at T+1.
- rsp_valid[0] with rsp_result=6 and rsp_err=0 one cycle after eng_done.

REQ-021 Bypass cases:
- req 2, a=0, b=35: rsp_valid[2] at T+1 with result 35, eng_start never high.
- a=0, b=0: result 0.
- a=7, b=0: result 7.

REQ-022 Fairness: all four req_valid held high, each operand pair distinct.
- Grant order SHALL be 0,1,2,3,0,1.
- Each result SHALL match a reference GCD.

REQ-023 Backpressure: hold rsp_ready[1]=0 for 5 cycles in RESP.
- rsp_valid[1], rsp_result and rsp_err SHALL stay stable.
- req_ready SHALL stay 0.
- Raising rsp_ready[1] returns the FSM to IDLE.

REQ-024 Timeout: TIMEOUT_CYC=16 and an engine model that never pulses done.
- rsp_err=1 and rsp_result=0 in RESP, 16 WAIT cycles after eng_start.
- A late eng_done SHALL be ignored.

REQ-025 Reset mid-WAIT: drop rsi_reset_n between clock edges.
- All outputs SHALL go to 0 before the next edge.
- After release, requesters 0 and 3 both valid: requester 0 SHALL be granted.

Source files
------------

// File: rtl/gcd_sched.sv
// Round-robin scheduler that shares one multi-cycle GCD engine among N_REQ requesters.
// Zero operands bypass the engine; an optional watchdog turns a hung engine into an error response.
module gcd_sched #(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 32,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic                       csi_clk,
   input  logic                       rsi_reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*WIDTH-1:0]     req_a,
   input  logic [N_REQ*WIDTH-1:0]     req_b,
   output logic [N_REQ-1:0]           rsp_valid,
   input  logic [N_REQ-1:0]           rsp_ready,
   output logic [WIDTH-1:0]           rsp_result,
   output logic                       rsp_err,
   output logic                       eng_start,
   output logic [WIDTH-1:0]           eng_dataa,
   output logic [WIDTH-1:0]           eng_datab,
   input  logic                       eng_done,
   input  logic [WIDTH-1:0]           eng_result,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id
);

   localparam int GW = $clog2(N_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     last_q, last_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              err_q, err_d;
   logic [31:0]       wd_q, wd_d;
   logic              wd_hit;

   logic [WIDTH-1:0]  a_arr [N_REQ];
   logic [WIDTH-1:0]  b_arr [N_REQ];
   logic              win_found;
   logic [GW-1:0]     win_idx;
   logic [GW:0]       cand;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
         assign rsp_valid[gi] = (state_q == S_RESP) && (grant_q == GW'(gi));
      end
   endgenerate

   // Search starts one past the last grantee and wraps modulo N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, last_q} + (GW+1)'(k);
         if (cand >= (GW+1)'(N_REQ)) begin
            cand = cand - (GW+1)'(N_REQ);
         end
         if (!win_found && req_valid[cand[GW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[GW-1:0];
         end
      end
   end

   assign wd_hit = (TIMEOUT_CYC != 0) && ((wd_q + 32'd1) == 32'(TIMEOUT_CYC));

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      err_d     = err_q;
      wd_d      = wd_q;
      req_ready = '0;
      eng_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            // req_ready is gated by reset so it drops the instant reset asserts.
            if (win_found && rsi_reset_n) begin
               req_ready[win_idx] = 1'b1;
               a_d     = a_arr[win_idx];
               b_d     = b_arr[win_idx];
               grant_d = win_idx;
               err_d   = 1'b0;
               if ((a_arr[win_idx] == '0) || (b_arr[win_idx] == '0)) begin
                  res_d   = a_arr[win_idx] | b_arr[win_idx];
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            eng_start = 1'b1;
            wd_d      = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + 32'd1;
            if (eng_done) begin
               res_d   = eng_result;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (wd_hit) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready[grant_q]) begin
               last_d  = grant_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         state_q <= S_IDLE;
         last_q  <= GW'(N_REQ-1);
         grant_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
      end
   end

   assign eng_dataa  = a_q;
   assign eng_datab  = b_q;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != S_IDLE);
   assign grant_id   = grant_q;

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a behavioural subtractive GCD engine attached.
module tb_gcd_sched;
   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0]   req_a, req_b;
   logic [W-1:0]     rsp_result, eng_dataa, eng_datab, eng_result, model_res;
   logic             rsp_err, eng_start, eng_done, model_done, man_done, busy, eng_hang;
   logic [1:0]       grant_id;
   logic [W-1:0]     ex, ey;
   logic             erun;
   int               n_tests = 0;
   int               n_fail = 0;
   int               start_cnt = 0;

   assign eng_done   = model_done | man_done;
   assign eng_result = man_done ? 32'hDEAD_BEEF : model_res;

   gcd_sched #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(16)) dut (
      .csi_clk(clk), .rsi_reset_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
      .eng_start(eng_start), .eng_dataa(eng_dataa), .eng_datab(eng_datab),
      .eng_done(eng_done), .eng_result(eng_result), .busy(busy), .grant_id(grant_id)
   );

   // Subtractive GCD engine; eng_hang suppresses the done pulse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         erun <= 1'b0; model_done <= 1'b0; model_res <= '0; ex <= '0; ey <= '0;
      end else begin
         model_done <= 1'b0;
         if (eng_start) begin
            ex <= eng_dataa; ey <= eng_datab; erun <= 1'b1;
         end else if (erun) begin
            if (ex == ey) begin
               erun <= 1'b0;
               if (!eng_hang) begin model_done <= 1'b1; model_res <= ex; end
            end else if (ex > ey) ex <= ex - ey;
            else ey <= ey - ex;
         end
      end
   end

   always @(posedge clk) if (eng_start) start_cnt++;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = 0x%0h", tag, got);
      end
   endtask

   task automatic wait_rsp(input string tag);
      int i;
      i = 0;
      while (rsp_valid == '0 && i < 60) begin tick(); i++; end
      check_eq(tag, 32'(rsp_valid != '0), 32'd1);
   endtask

   // One isolated request on index g; bypass path chosen when an operand is zero.
   task automatic do_req(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
      int sc;
      req_a[g*W +: W] = a;
      req_b[g*W +: W] = b;
      req_valid = 4'(1 << g);
      #1;
      check_eq("req_ready_onehot", 32'(req_ready), 32'(1 << g));
      sc = start_cnt;
      tick();
      req_valid = '0;
      req_a[g*W +: W] = '1;
      req_b[g*W +: W] = '1;
      if (a == '0 || b == '0) begin
         check_eq("bypass_rsp_valid", 32'(rsp_valid), 32'(1 << g));
      end else begin
         check_eq("eng_start", 32'(eng_start), 32'd1);
         check_eq("eng_dataa", eng_dataa, a);
         check_eq("eng_datab", eng_datab, b);
         for (int i = 0; i < 40 && !eng_done; i++) tick();
         check_eq("eng_done_seen", 32'(eng_done), 32'd1);
         check_eq("rsp_valid_during_done", 32'(rsp_valid), 32'd0);
         tick();
         check_eq("rsp_valid_after_done", 32'(rsp_valid), 32'(1 << g));
      end
      check_eq("rsp_result", rsp_result, exp);
      check_eq("rsp_err", 32'(rsp_err), 32'd0);
      check_eq("grant_id", 32'(grant_id), 32'(g));
      rsp_ready = 4'(1 << g);
      tick();
      rsp_ready = '0;
      check_eq("busy_after_hs", 32'(busy), 32'd0);
      if (a == '0 || b == '0) check_eq("bypass_no_start", 32'(start_cnt - sc), 32'd0);
   endtask

   int          ord [6]  = '{0, 1, 2, 3, 0, 1};
   logic [31:0] fres [6] = '{32'd4, 32'd3, 32'd5, 32'd7, 32'd4, 32'd3};

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
      man_done = 1'b0; eng_hang = 1'b0;
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_eng_start", 32'(eng_start), 32'd0);
      check_eq("rst_grant_id", 32'(grant_id), 32'd0);
      check_eq("rst_result", rsp_result, 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      do_req(0, 32'd48, 32'd18, 32'd6);
      do_req(2, 32'd0, 32'd35, 32'd35);
      do_req(3, 32'd0, 32'd0, 32'd0);

      // Fairness: all four held valid, last grant is 3 so 0 goes first.
      req_a[0*W +: W] = 32'd12; req_b[0*W +: W] = 32'd8;
      req_a[1*W +: W] = 32'd9;  req_b[1*W +: W] = 32'd6;
      req_a[2*W +: W] = 32'd25; req_b[2*W +: W] = 32'd15;
      req_a[3*W +: W] = 32'd14; req_b[3*W +: W] = 32'd21;
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         wait_rsp("fair_wait");
         check_eq("fair_grant", 32'(grant_id), 32'(ord[k]));
         check_eq("fair_rsp_valid", 32'(rsp_valid), 32'(1 << ord[k]));
         check_eq("fair_result", rsp_result, fres[k]);
         rsp_ready = 4'(1 << ord[k]);
         tick();
         rsp_ready = '0;
      end
      req_valid = '0;

      do_req(0, 32'd7, 32'd0, 32'd7);

      // Watchdog: engine never signals done.
      eng_hang = 1'b1;
      req_a[0*W +: W] = 32'd10; req_b[0*W +: W] = 32'd4;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      check_eq("to_eng_start", 32'(eng_start), 32'd1);
      for (int i = 0; i < 16; i++) tick();
      check_eq("to_not_yet", 32'(rsp_valid), 32'd0);
      check_eq("to_dataa_held", eng_dataa, 32'd10);
      tick();
      check_eq("to_rsp_valid", 32'(rsp_valid), 32'b0001);
      check_eq("to_err", 32'(rsp_err), 32'd1);
      check_eq("to_result", rsp_result, 32'd0);
      man_done = 1'b1; tick(); man_done = 1'b0;
      check_eq("late_done_result", rsp_result, 32'd0);
      check_eq("late_done_err", 32'(rsp_err), 32'd1);
      rsp_ready = 4'b0001; tick(); rsp_ready = '0;
      man_done = 1'b1; tick(); man_done = 1'b0;
      check_eq("idle_done_busy", 32'(busy), 32'd0);
      eng_hang = 1'b0;

      // Backpressure on requester 1 with a stray ready on index 2.
      req_a[1*W +: W] = 32'd9; req_b[1*W +: W] = 32'd6;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      wait_rsp("bp_wait");
      req_valid = 4'b1111;
      rsp_ready = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
         check_eq("bp_result", rsp_result, 32'd3);
         check_eq("bp_err", 32'(rsp_err), 32'd0);
         check_eq("bp_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      check_eq("bp_idle", 32'(busy), 32'd0);
      check_eq("bp_next_winner", 32'(req_ready), 32'b0100);
      req_valid = '0;

      // Reset in the middle of WAIT.
      req_a[2*W +: W] = 32'd48; req_b[2*W +: W] = 32'd18;
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      tick(); tick();
      check_eq("mid_busy", 32'(busy), 32'd1);
      req_valid = 4'b1001;
      #1 rst_n = 1'b0;
      #1;
      check_eq("ar_busy", 32'(busy), 32'd0);
      check_eq("ar_req_ready", 32'(req_ready), 32'd0);
      check_eq("ar_dataa", eng_dataa, 32'd0);
      check_eq("ar_datab", eng_datab, 32'd0);
      check_eq("ar_grant", 32'(grant_id), 32'd0);
      check_eq("ar_result", rsp_result, 32'd0);
      check_eq("ar_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      req_a[0*W +: W] = 32'd21; req_b[0*W +: W] = 32'd14;
      req_a[3*W +: W] = 32'd5;  req_b[3*W +: W] = 32'd10;
      rst_n = 1'b1;
      tick();
      req_valid = '0;
      check_eq("post_rst_grant", 32'(grant_id), 32'd0);
      check_eq("post_rst_start", 32'(eng_start), 32'd1);
      wait_rsp("post_rst_wait");
      check_eq("post_rst_result", rsp_result, 32'd7);
      rsp_ready = 4'b0001; tick(); rsp_ready = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
